// File: rtl/snn_activity_monitor.sv
// rtl/snn_activity_monitor.sv - windowed event/spike counters and input-to-output latency monitor for snn_layer
module snn_activity_monitor #(
    parameter int FAN_IN      = 128,
    parameter int NUM_NEURONS = 1,
    parameter int CNT_W       = 32,
    parameter int TS_W        = 16,
    parameter int LAT_W       = 40,
    parameter int FIFO_DEPTH  = 16,
    localparam int LSEL_W     = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [FAN_IN-1:0]      pre_spikes,
    input  logic [NUM_NEURONS-1:0] post_spikes,
    input  logic [LSEL_W-1:0]      lat_sel,
    input  logic [CNT_W-1:0]       win_cycles,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       cycles,
    output logic [CNT_W-1:0]       in_events,
    output logic [CNT_W-1:0]       out_spikes,
    output logic [LAT_W-1:0]       lat_sum,
    output logic [CNT_W-1:0]       lat_samples,
    output logic [TS_W-1:0]        lat_last,
    output logic                   fifo_ovf,
    output logic                   sat
);
    localparam int PC_W = $clog2(FAN_IN + 1);
    localparam int PO_W = $clog2(NUM_NEURONS + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t state, state_nxt;

    logic                  clear, sample;
    logic [TS_W-1:0]       ts;
    logic [TS_W-1:0]       fifo_ts  [FIFO_DEPTH];
    logic [PC_W-1:0]       fifo_cnt [FIFO_DEPTH];
    logic [AW:0]           wr_ptr, rd_ptr;

    logic [PC_W-1:0]       pre_pc, push_cnt;
    logic [PO_W-1:0]       post_pc;
    logic [NUM_NEURONS-1:0] post_sh;
    logic                  lat_spike, take, fifo_empty, fifo_full;
    logic                  push_en, retire, dec_head, drop;
    logic [TS_W-1:0]       head_ts, latency;
    logic [PC_W-1:0]       head_cnt;
    logic [CNT_W:0]        cyc_add, ine_add, outs_add, samp_add;
    logic [LAT_W:0]        lsum_add;

    function automatic logic [CNT_W:0] add_cnt(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? {1'b1, {CNT_W{1'b1}}} : s;
    endfunction

    function automatic logic [LAT_W:0] add_lat(input logic [LAT_W-1:0] a, input logic [LAT_W-1:0] b);
        logic [LAT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[LAT_W] ? {1'b1, {LAT_W{1'b1}}} : s;
    endfunction

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    // Popcounts, FIFO status and the latency pop/push decision for this cycle
    always_comb begin
        pre_pc  = '0;
        post_pc = '0;
        for (int i = 0; i < FAN_IN; i++) pre_pc = pre_pc + PC_W'(pre_spikes[i]);
        for (int i = 0; i < NUM_NEURONS; i++) post_pc = post_pc + PO_W'(post_spikes[i]);
        post_sh    = post_spikes >> lat_sel;
        lat_spike  = post_sh[0];
        fifo_empty = (wr_ptr == rd_ptr);
        fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        head_ts    = fifo_ts[rd_ptr[AW-1:0]];
        head_cnt   = fifo_cnt[rd_ptr[AW-1:0]];
        take       = lat_spike && (!fifo_empty || pre_pc != '0);
        latency    = '0;
        retire     = 1'b0;
        dec_head   = 1'b0;
        drop       = 1'b0;
        push_cnt   = pre_pc;
        push_en    = 1'b0;
        if (fifo_empty) begin
            // This cycle's batch is the head: consume one event before it is stored
            if (take) push_cnt = pre_pc - PC_W'(1);
            push_en = (push_cnt != '0);
        end else begin
            latency  = ts - head_ts;
            retire   = take && (head_cnt == PC_W'(1));
            dec_head = take && (head_cnt != PC_W'(1));
            push_en  = (pre_pc != '0) && (!fifo_full || retire);
            drop     = (pre_pc != '0) && fifo_full && !retire;
        end
        cyc_add  = add_cnt(cycles, CNT_W'(1));
        ine_add  = add_cnt(in_events, CNT_W'(pre_pc));
        outs_add = add_cnt(out_spikes, CNT_W'(post_pc));
        samp_add = add_cnt(lat_samples, CNT_W'(take));
        lsum_add = add_lat(lat_sum, take ? LAT_W'(latency) : '0);
    end

    // Measurement state machine: abort wins, window end or stop closes RUN
    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        sample    = 1'b0;
        if (abort) begin
            state_nxt = S_IDLE;
            clear     = 1'b1;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_nxt = S_RUN;
                        clear     = 1'b1;
                    end
                end
                S_RUN: begin
                    sample = 1'b1;
                    if (stop || (win_cycles != '0 && cyc_add[CNT_W-1:0] == win_cycles))
                        state_nxt = S_DONE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // State, counters, flags and FIFO pointers
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state       <= rst_n ? state_nxt : S_IDLE;
            ts          <= '0;
            cycles      <= '0;
            in_events   <= '0;
            out_spikes  <= '0;
            lat_sum     <= '0;
            lat_samples <= '0;
            lat_last    <= '0;
            fifo_ovf    <= 1'b0;
            sat         <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            state <= state_nxt;
            if (sample) begin
                ts          <= ts + TS_W'(1);
                cycles      <= cyc_add[CNT_W-1:0];
                in_events   <= ine_add[CNT_W-1:0];
                out_spikes  <= outs_add[CNT_W-1:0];
                lat_samples <= samp_add[CNT_W-1:0];
                lat_sum     <= lsum_add[LAT_W-1:0];
                lat_last    <= take ? latency : '0;
                fifo_ovf    <= fifo_ovf | drop;
                sat         <= sat | cyc_add[CNT_W] | ine_add[CNT_W] | outs_add[CNT_W]
                               | samp_add[CNT_W] | lsum_add[LAT_W];
                if (push_en) wr_ptr <= wr_ptr + (AW+1)'(1);
                if (retire)  rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // FIFO storage: push a new batch and decrement the head in place
    always_ff @(posedge clk) begin
        if (rst_n && sample && !clear) begin
            if (dec_head) fifo_cnt[rd_ptr[AW-1:0]] <= head_cnt - PC_W'(1);
            if (push_en) begin
                fifo_ts[wr_ptr[AW-1:0]]  <= ts;
                fifo_cnt[wr_ptr[AW-1:0]] <= push_cnt;
            end
        end
    end
endmodule

// File: tb/tb_snn_activity_monitor.sv
// tb/tb_snn_activity_monitor.sv - scoreboard bench for snn_activity_monitor
module tb_snn_activity_monitor;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  pre_spikes;
    logic [1:0]  post_spikes;
    logic [0:0]  lat_sel;
    logic [15:0] win_cycles;
    logic        start, stop, abort;
    logic        busy, done, fifo_ovf, sat;
    logic [15:0] cycles, in_events, out_spikes, lat_samples;
    logic [19:0] lat_sum;
    logic [7:0]  lat_last;

    snn_activity_monitor #(
        .FAN_IN(8), .NUM_NEURONS(2), .CNT_W(16), .TS_W(8), .LAT_W(20), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pre_spikes(pre_spikes), .post_spikes(post_spikes),
        .lat_sel(lat_sel), .win_cycles(win_cycles), .start(start), .stop(stop), .abort(abort),
        .busy(busy), .done(done), .cycles(cycles), .in_events(in_events), .out_spikes(out_spikes),
        .lat_sum(lat_sum), .lat_samples(lat_samples), .lat_last(lat_last),
        .fifo_ovf(fifo_ovf), .sat(sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc; int ine; int outs; int lsum; int samp; int last; int ovf;
    } res_t;

    res_t res_q[$];
    int   lat_q[$];
    int   n_pass = 0;
    int   n_tot  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic push_res(input int c, input int i, input int o, input int s,
                            input int n, input int l, input int v);
        res_t r;
        r.cyc = c; r.ine = i; r.outs = o; r.lsum = s; r.samp = n; r.last = l; r.ovf = v;
        res_q.push_back(r);
    endtask

    task automatic step(input logic [7:0] p, input logic [1:0] q,
                        input logic st, input logic sp, input logic ab);
        pre_spikes = p; post_spikes = q; start = st; stop = sp; abort = ab;
        @(posedge clk);
        #1;
    endtask

    // Monitor: latency samples and end-of-window results, compared against the queues
    logic        done_prev = 1'b0;
    logic [15:0] samp_prev = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (lat_samples == samp_prev + 16'd1) begin
                if (lat_q.size() == 0) chk("unexpected_lat_sample", int'(lat_samples), 0);
                else chk("lat_last_sample", int'(lat_last), lat_q.pop_front());
            end
            if (done && !done_prev) begin
                if (res_q.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    res_t r;
                    r = res_q.pop_front();
                    chk("cycles", int'(cycles), r.cyc);
                    chk("in_events", int'(in_events), r.ine);
                    chk("out_spikes", int'(out_spikes), r.outs);
                    chk("lat_sum", int'(lat_sum), r.lsum);
                    chk("lat_samples", int'(lat_samples), r.samp);
                    chk("lat_last_end", int'(lat_last), r.last);
                    chk("fifo_ovf", int'(fifo_ovf), r.ovf);
                    chk("sat", int'(sat), 0);
                end
            end
        end
        done_prev <= done;
        samp_prev <= lat_samples;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; lat_sel = 1'b0; win_cycles = '0;
        repeat (3) step(8'h00, 2'b00, 1'b0, 1'b0, 1'b0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_counts", int'(cycles) + int'(in_events) + int'(out_spikes) + int'(lat_samples), 0);
        chk("rst_lat", int'(lat_sum) + int'(lat_last), 0);
        chk("rst_flags", int'({fifo_ovf, sat}), 0);
        rst_n = 1'b1;

        step(8'h00, 2'b00, 1'b0, 1'b1, 1'b0);
        chk("stop_in_idle", int'(busy), 0);

        // Window of 10 with 3 events per cycle; FIFO (depth 4) overflows
        win_cycles = 16'd10;
        push_res(10, 30, 0, 0, 0, 0, 1);
        step(8'h00, 2'b00, 1'b1, 1'b0, 1'b0);
        chk("busy_after_start", int'(busy), 1);
        for (int i = 0; i < 10; i++) step(8'h07, 2'b00, 1'b0, 1'b0, 1'b0);
        repeat (2) step(8'h00, 2'b00, 1'b0, 1'b0, 1'b0);
        chk("done_holds", int'(done), 1);
        chk("busy_in_done", int'(busy), 0);

        // One event at cycle 2, post spike at cycle 7 -> latency 5
        win_cycles = 16'd9;
        push_res(9, 1, 1, 5, 1, 0, 0);
        lat_q.push_back(5);
        step(8'h00, 2'b00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++)
            step((i == 2) ? 8'h01 : 8'h00, (i == 7) ? 2'b01 : 2'b00, 1'b0, 1'b0, 1'b0);
        step(8'h00, 2'b00, 1'b0, 1'b0, 1'b0);

        // Batch of 4 at cycle 0, spikes at cycles 1..5; start at cycle 3 ignored
        win_cycles = 16'd6;
        push_res(6, 4, 5, 10, 4, 0, 0);
        for (int k = 1; k <= 4; k++) lat_q.push_back(k);
        step(8'h00, 2'b00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)
            step((i == 0) ? 8'h0F : 8'h00, (i >= 1) ? 2'b01 : 2'b00, (i == 3), 1'b0, 1'b0);
        step(8'h00, 2'b00, 1'b0, 1'b0, 1'b0);

        // Event and spike in the same cycle with the FIFO empty -> latency 0
        win_cycles = 16'd3;
        push_res(3, 1, 1, 0, 1, 0, 0);
        lat_q.push_back(0);
        step(8'h00, 2'b00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step((i == 1) ? 8'h01 : 8'h00, (i == 1) ? 2'b01 : 2'b00, 1'b0, 1'b0, 1'b0);
        step(8'h00, 2'b00, 1'b0, 1'b0, 1'b0);

        // Six consecutive events into a depth-4 FIFO
        win_cycles = 16'd6;
        push_res(6, 6, 0, 0, 0, 0, 1);
        step(8'h00, 2'b00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(8'h01, 2'b00, 1'b0, 1'b0, 1'b0);
        step(8'h00, 2'b00, 1'b0, 1'b0, 1'b0);

        // lat_sel = 1: neuron 0 spike does not pop, neuron 1 spike does
        lat_sel = 1'b1;
        win_cycles = 16'd4;
        push_res(4, 1, 2, 3, 1, 3, 0);
        lat_q.push_back(3);
        step(8'h00, 2'b00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            step((i == 0) ? 8'h01 : 8'h00, (i == 2) ? 2'b01 : ((i == 3) ? 2'b10 : 2'b00),
                 1'b0, 1'b0, 1'b0);
        step(8'h00, 2'b00, 1'b0, 1'b0, 1'b0);
        lat_sel = 1'b0;

        // Abort mid-run, then an unbounded run closed by stop on its 8th cycle
        win_cycles = 16'd0;
        step(8'h00, 2'b00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(8'h03, 2'b00, 1'b0, 1'b0, 1'b0);
        step(8'h01, 2'b00, 1'b1, 1'b1, 1'b1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_counts", int'(cycles) + int'(in_events), 0);
        chk("abort_ovf", int'(fifo_ovf), 0);
        push_res(8, 1, 1, 3, 1, 0, 0);
        lat_q.push_back(3);
        step(8'h00, 2'b00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            step((i == 2) ? 8'h01 : 8'h00, (i == 5) ? 2'b01 : 2'b00, 1'b0, (i == 7), 1'b0);
        repeat (3) step(8'h00, 2'b00, 1'b0, 1'b0, 1'b0);

        chk("results_drained", res_q.size(), 0);
        chk("latencies_drained", lat_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/snn_activity_monitor.md
# snn_activity_monitor

Synthesizable run-time performance monitor for an `snn_layer` instance. It taps the layer's `pre_spikes` and `post_spikes` buses and counts input events and output spikes over a programmable measurement window. It also measures input-to-output spike latency in cycles, using a FIFO of per-cycle event batches. It replaces bench-only throughput/latency scoring with hardware counters readable by a host or by the fan-in sweep benches.

## Interface
Parameters:
- `FAN_IN`, 128: width of `pre_spikes`.
- `NUM_NEURONS`, 1: width of `post_spikes`.
- `CNT_W`, 32: width of the event, spike and sample counters.
- `TS_W`, 16: width of the timestamp and latency values (cycles).
- `LAT_W`, 40: width of the latency accumulator.
- `FIFO_DEPTH`, 16: number of batch entries; power of two, at least 2.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `pre_spikes`, in, `FAN_IN`: input spike vector, sampled every cycle.
- `post_spikes`, in, `NUM_NEURONS`: output spike vector, sampled every cycle.
- `lat_sel`, in, `$clog2(NUM_NEURONS)` (min 1): neuron whose spikes consume latency events; held stable during RUN.
- `win_cycles`, in, `CNT_W`: window length in cycles; 0 means unbounded (run until `stop`).
- `start`, in, 1: pulse; begins a measurement.
- `stop`, in, 1: pulse; ends RUN early.
- `abort`, in, 1: pulse; return to IDLE and clear results.
- `busy`, out, 1: high in RUN.
- `done`, out, 1: high in DONE.
- `cycles`, out, `CNT_W`: cycles sampled in the window.
- `in_events`, out, `CNT_W`: total popcount of `pre_spikes`.
- `out_spikes`, out, `CNT_W`: total popcount of `post_spikes`.
- `lat_sum`, out, `LAT_W`: sum of the measured latencies.
- `lat_samples`, out, `CNT_W`: number of latency samples.
- `lat_last`, out, `TS_W`: most recent latency sample.
- `fifo_ovf`, out, 1: sticky; an input batch was dropped.
- `sat`, out, 1: sticky; some counter saturated.

## Operation
- States: IDLE, RUN, DONE.
- IDLE and `start` → RUN. All counters, `lat_last`, the flags and the FIFO clear; the timestamp resets to 0.
- RUN → DONE when `stop` is high, or when `win_cycles != 0` and the cycle being sampled is number `win_cycles` (i.e. `cycles` becomes `win_cycles`). That cycle's spikes are counted.
- DONE: results are frozen. `start` → RUN with a fresh clear.
- `abort` in any state → IDLE with everything cleared. `abort` has priority over `start` and `stop`.
- `start` in RUN is ignored. `stop` outside RUN is ignored.
- Per RUN cycle:
  - `ts` increments modulo 2^TS_W.
  - `in_events += popcount(pre_spikes)`.
  - `out_spikes += popcount(post_spikes)`.
  - `cycles += 1`.
- FIFO entry = {`ts`, count}, with count width `$clog2(FAN_IN+1)`. A cycle with nonzero popcount pushes one entry holding the current `ts` and the popcount.
- Latency pop happens when `post_spikes[lat_sel]` is high and events are available:
  - Events are available if the FIFO is non-empty or this cycle's batch is nonzero.
  - The head is the oldest event. This cycle's batch is logically pushed before the pop, so the latency is 0 if the FIFO was empty.
  - latency = (`ts` − head.ts) mod 2^TS_W.
  - The head count decrements; the entry retires when the count reaches 0.
  - `lat_sum += latency`; `lat_samples += 1`; `lat_last = latency`.
- Latency pop when no events are available: no sample is taken and `lat_last` becomes 0.
- Latency pop when no `lat_sel` spike this cycle: `lat_last` becomes 0.
- At most one pop per cycle.
- FIFO full with a push pending and no retiring pop: the new batch is dropped and `fifo_ovf` is set. A push coinciding with a retire is accepted.
- Counters saturate at all-ones and set `sat`; they never wrap. The timestamp wraps by design; correct latency requires a true latency < 2^TS_W.

## Timing
- Reset (`rst_n` = 0 at an edge): state IDLE. Every output is 0, including `busy`, `done`, all counters, `lat_last`, `fifo_ovf` and `sat`. The FIFO is empty.
- Reset mid-RUN is equivalent to `abort`.
- All outputs are registered. Spikes sampled at edge t are reflected in the outputs after edge t. `busy` rises the cycle after `start` is sampled. The first sampled cycle is the edge after `start`.
- `done` rises the cycle after the last sampled edge and holds until `start` or `abort`.
- The FIFO head is read combinationally from the register array, so a pop takes no extra latency.

## Test plan
- `win_cycles`=10, `pre_spikes` = 3 bits set every cycle, no post spikes → `done`, `cycles`=10, `in_events`=30, `lat_samples`=0.
- Single input event at run cycle 2; `post_spikes[0]` at cycle 7 → `lat_samples`=1, `lat_sum`=5, `lat_last` pulses 5.
- Batch of 4 events at cycle 0; post spike every cycle at cycles 1–5 → samples 1,2,3,4, `lat_sum`=10, `lat_samples`=4; the cycle-5 spike yields no sample; the FIFO ends empty.
- An input event and a post spike in the same cycle with the FIFO empty → latency 0, `lat_samples`=1.
- `FIFO_DEPTH`=4, events on 6 consecutive cycles, no post spikes → `fifo_ovf`=1, `in_events`=6 (counting is unaffected).
- `abort` mid-RUN, then `start` with `win_cycles`=0 and `stop` after 8 cycles → all counts reflect only the second run, `cycles`=8.
